// File: rtl/ccff_chain_driver.sv
// -----------------------------------------------------------------------------
// ccff_chain_driver
//   Streams configuration words into a serial configuration flip-flop (ccff)
//   chain, one bit per prog_clk, bit 0 of each word first. Exactly CHAIN_LEN
//   bits are pushed per load; trailing bits of the last word are discarded.
//   While bits are shifted, the bits returned from the chain tail are folded
//   into a running parity.
//
// Ports
//   prog_clk       : single clock, all state on its rising edge
//   prog_reset     : synchronous active-high reset, beats every other input
//   cfg_start      : begin a load (only looked at in IDLE)
//   cfg_abort      : terminate a load in progress (only acts in SHIFT)
//   word_valid     : word_data carries a configuration word
//   word_ready     : driver takes word_data this cycle
//   word_data      : configuration word, index 0 shifted first
//   ccff_head      : serial bit into the chain head
//   ccff_shift_en  : chain clock enable, high only when ccff_head is valid
//   ccff_tail      : serial bit coming back from the chain tail
//   busy           : high while in SHIFT
//   done           : one-cycle pulse after a load completes normally
//   aborted        : sticky, set by cfg_abort in SHIFT, cleared by cfg_start
//   tail_parity    : XOR of all tail bits shifted out during the last load
// -----------------------------------------------------------------------------
module ccff_chain_driver #(
  parameter int CHAIN_LEN = 14,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [0:WORD_W-1] word_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              tail_parity
);

  localparam int TOT_W = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            r_state;
  logic [0:WORD_W-1] r_sh_data;   // index 0 is the next bit to leave
  logic [CNT_W-1:0]  r_sh_cnt;    // bits still held in r_sh_data
  logic [TOT_W-1:0]  r_tot_cnt;   // bits pushed into the chain this load
  logic              r_done;
  logic              r_aborted;
  logic              r_parity;

  logic              w_shift;
  logic              w_accept;
  logic              w_last;
  logic [31:0]       w_committed;

  // A bit goes out whenever the shift register holds one; an empty register
  // simply freezes the chain until the next word arrives.
  assign w_shift = (r_state == S_SHIFT) && (r_sh_cnt != '0);

  // Bits already shifted plus bits still buffered. A new word is only wanted
  // while this falls short of the chain length (pending > 0), and only once
  // the buffer is down to its last bit so the reload lands with no bubble.
  assign w_committed = 32'(r_tot_cnt) + 32'(r_sh_cnt);
  assign word_ready  = (r_state == S_SHIFT) &&
                       (w_committed < 32'(CHAIN_LEN)) &&
                       (r_sh_cnt <= CNT_W'(1));
  assign w_accept    = word_valid && word_ready;

  // This shift delivers the final chain bit.
  assign w_last = w_shift && ((32'(r_tot_cnt) + 32'd1) == 32'(CHAIN_LEN));

  assign ccff_shift_en = w_shift;
  assign ccff_head     = w_shift ? r_sh_data[0] : 1'b0;
  assign busy          = (r_state == S_SHIFT);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign tail_parity   = r_parity;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state   <= S_IDLE;
      r_sh_data <= '0;
      r_sh_cnt  <= '0;
      r_tot_cnt <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_parity  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Parity and aborted are held here until the next load begins.
          if (cfg_start) begin
            r_state   <= S_SHIFT;
            r_tot_cnt <= '0;
            r_sh_cnt  <= '0;
            r_parity  <= 1'b0;
            r_aborted <= 1'b0;
          end
        end

        S_SHIFT: begin
          // The chain is clocked on every w_shift cycle, including an abort
          // cycle, so count and parity always track what really left.
          if (w_shift) begin
            r_tot_cnt <= r_tot_cnt + TOT_W'(1);
            r_parity  <= r_parity ^ ccff_tail;
          end

          // A handshake reloads the buffer; it replaces the shift of the
          // outgoing last bit rather than competing with it.
          if (w_accept) begin
            r_sh_data <= word_data;
            r_sh_cnt  <= CNT_W'(WORD_W);
          end else if (w_shift) begin
            r_sh_data <= {r_sh_data[1:WORD_W-1], 1'b0};
            r_sh_cnt  <= r_sh_cnt - CNT_W'(1);
          end

          // Abort outranks completion; either way leftover buffered bits
          // are dropped.
          if (cfg_abort) begin
            r_state   <= S_IDLE;
            r_sh_cnt  <= '0;
            r_aborted <= 1'b1;
          end else if (w_last) begin
            r_state  <= S_IDLE;
            r_sh_cnt <= '0;
            r_done   <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_driver.sv
module tb_ccff_chain_driver;
  localparam int CHAIN_LEN = 14;
  localparam int WORD_W    = 8;
  localparam int NEED      = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              prog_clk = 1'b0;
  logic              prog_reset, cfg_start, cfg_abort, word_valid, word_ready;
  logic [0:WORD_W-1] word_data;
  logic              ccff_head, ccff_shift_en, ccff_tail;
  logic              busy, done, aborted, tail_parity;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_driver #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(cfg_start),
    .cfg_abort(cfg_abort), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
    .ccff_tail(ccff_tail), .busy(busy), .done(done), .aborted(aborted),
    .tail_parity(tail_parity)
  );

  // Downstream chain model: plain shift register clocked by shift_en.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] pre_val;
  logic                 pre_req = 1'b0;
  always @(posedge prog_clk) begin
    if (pre_req) chain <= pre_val;
    else if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard
  typedef struct { logic b; int cyc; } bit_exp_t;
  typedef struct { logic p; int cyc; } done_exp_t;
  bit_exp_t  q_bits[$];
  done_exp_t q_done[$];
  int base = 0;

  always @(negedge prog_clk) begin
    bit_exp_t  eb;
    done_exp_t ed;
    if (ccff_shift_en === 1'b1) begin
      if (q_bits.size() == 0) chk("unexpected_shift", 1, 0);
      else begin
        eb = q_bits.pop_front();
        chk("head_bit", int'(ccff_head), int'(eb.b));
        if (eb.cyc >= 0) chk("bit_cycle", cyc - base, eb.cyc);
      end
    end
    if (done === 1'b1) begin
      if (q_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ed = q_done.pop_front();
        chk("parity_at_done", int'(tail_parity), int'(ed.p));
        if (ed.cyc >= 0) chk("done_cycle", cyc - base, ed.cyc);
      end
    end
  end

  // Stimulus state
  logic [0:WORD_W-1] words[4];
  int   nw;
  int   hs_cnt;
  logic ab_at1;

  function automatic bit valid_at(input int mode, input int rel);
    case (mode)
      0:       return 1'b1;
      1:       return !(rel >= 9 && rel <= 11);
      default: return ($urandom_range(3) != 0);
    endcase
  endfunction

  // Expected stream: first n bits of the word sequence, index 0 of each word
  // first. With valid held, bit i appears in cycle 2+i; a 3-cycle gap in
  // front of the second word delays every bit of it by 3.
  task automatic push_bits(input int n, input int mode);
    bit_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b   = words[i / WORD_W][i % WORD_W];
      e.cyc = (mode == 0) ? 2 + i : (mode == 1) ? ((i < WORD_W) ? 2 + i : 5 + i) : -1;
      q_bits.push_back(e);
    end
  endtask

  task automatic push_done(input logic p, input int c);
    done_exp_t d;
    d.p = p; d.cyc = c;
    q_done.push_back(d);
  endtask

  task automatic preload(input logic [CHAIN_LEN-1:0] v);
    pre_val = v; pre_req = 1'b1;
    @(posedge prog_clk); #1;
    pre_req = 1'b0;
  endtask

  // Runs one load starting at the current cycle (cycle 0). Returns #1 after
  // the edge at which the driver is back in IDLE.
  task automatic run_load(input int mode, input int abort_rel, input int reset_rel,
                          input int start_rel);
    int  widx, rel;
    bit  hs, fin;
    base = cyc; cfg_start = 1'b1; widx = 0; hs_cnt = 0; fin = 1'b0;
    word_valid = (nw > 0) && valid_at(mode, 0);
    word_data  = words[0];
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge prog_clk);
      hs = word_valid && word_ready;
      if (hs) hs_cnt++;
      if (cyc - base == 1) ab_at1 = aborted;
      @(posedge prog_clk); #1;
      rel = cyc - base;
      cfg_start  = (rel == start_rel);
      cfg_abort  = (rel == abort_rel);
      prog_reset = (rel == reset_rel);
      if (hs) widx++;
      word_valid = (widx < nw) && valid_at(mode, rel);
      word_data  = words[(widx < nw) ? widx : 0];
      if (rel >= 2 && !busy) fin = 1'b1;
    end
    if (!fin) chk("load_timeout", 0, 1);
    cfg_start = 1'b0; cfg_abort = 1'b0; prog_reset = 1'b0; word_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word_ready"}, int'(word_ready), 0);
    chk({tag, "_ccff_head"}, int'(ccff_head), 0);
    chk({tag, "_shift_en"}, int'(ccff_shift_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_aborted"}, int'(aborted), 0);
    chk({tag, "_tail_parity"}, int'(tail_parity), 0);
  endtask

  task automatic settle_and_check_queues(input string tag);
    repeat (3) @(posedge prog_clk);
    #1;
    chk({tag, "_bits_left"}, q_bits.size(), 0);
    chk({tag, "_done_left"}, q_done.size(), 0);
  endtask

  initial begin
    logic [CHAIN_LEN-1:0] pv;
    prog_reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    word_valid = 1'b0; word_data = '0;
    repeat (3) @(posedge prog_clk);
    #1;
    @(negedge prog_clk);
    check_all_zero("reset");
    @(posedge prog_clk); #1;
    prog_reset = 1'b0;
    @(posedge prog_clk); #1;

    // Directed load, valid held, a spare third word offered.
    words[0] = 8'b10110010; words[1] = 8'b01101111; words[2] = 8'b11111111;
    nw = 3;
    preload(14'b00000000000111);
    push_bits(CHAIN_LEN, 0);
    push_done(1'b1, 16);
    run_load(0, -1, -1, -1);
    chk("handshakes_held", hs_cnt, NEED);
    settle_and_check_queues("held");
    chk("parity_held_idle", int'(tail_parity), 1);
    chk("busy_idle", int'(busy), 0);

    // valid dropped for 3 cycles in front of the second word.
    preload(14'b00000000000011);
    push_bits(CHAIN_LEN, 1);
    push_done(1'b0, 19);
    run_load(1, -1, -1, -1);
    chk("handshakes_gap", hs_cnt, NEED);
    settle_and_check_queues("gap");

    // cfg_start re-asserted mid-load must change nothing.
    pv = CHAIN_LEN'($urandom);
    preload(pv);
    push_bits(CHAIN_LEN, 0);
    push_done(^pv, 16);
    run_load(0, -1, -1, 5);
    chk("handshakes_restart", hs_cnt, NEED);
    settle_and_check_queues("restart");

    // Abort after five bits: the sixth goes out in the abort cycle.
    preload(CHAIN_LEN'($urandom));
    push_bits(6, 0);
    run_load(0, 7, -1, -1);
    @(negedge prog_clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_flag", int'(aborted), 1);
    chk("abort_word_ready", int'(word_ready), 0);
    chk("abort_done", int'(done), 0);
    settle_and_check_queues("abort");
    chk("abort_sticky", int'(aborted), 1);

    // Next load clears aborted and runs normally.
    pv = CHAIN_LEN'($urandom);
    preload(pv);
    push_bits(CHAIN_LEN, 0);
    push_done(^pv, 16);
    run_load(0, -1, -1, -1);
    chk("abort_cleared", int'(ab_at1), 0);
    settle_and_check_queues("post_abort");

    // Reset in the middle of a load.
    preload(14'b10101010101011);
    push_bits(5, 0);
    run_load(0, -1, 6, -1);
    @(negedge prog_clk);
    check_all_zero("midreset");
    settle_and_check_queues("midreset");

    // Randomized loads.
    for (int t = 0; t < 20; t++) begin
      nw = NEED + 1;
      for (int w = 0; w < 4; w++) words[w] = WORD_W'($urandom);
      pv = CHAIN_LEN'($urandom);
      preload(pv);
      push_bits(CHAIN_LEN, 2);
      push_done(^pv, -1);
      run_load(2, -1, -1, -1);
      chk("handshakes_rand", hs_cnt, NEED);
      settle_and_check_queues("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
